// File: rtl/control_unit.sv
// Instruction sequencer for a single-issue datapath: fetch handshake, decode,
// single/multi-cycle execute with ALU timeout, writeback and halt.
module control_unit #(
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [W-1:0] instr,
  output logic         instr_ready,
  input  logic         alu_done,
  output logic         alu_start,
  output logic [5:0]   opcode,
  output logic [1:0]   read_sources_1,
  output logic [1:0]   read_sources_2,
  output logic [1:0]   write_destination,
  output logic         write_enable,
  output logic         busy,
  output logic         halted,
  output logic         error,
  output logic [15:0]  instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] EXEC_LAST = CW'(TIMEOUT - 1);

  // Only the decoded fields are kept; instr[3:0] carries nothing.
  typedef struct packed {
    logic [5:0] op;
    logic [1:0] dst;
    logic [1:0] src1;
    logic [1:0] src2;
  } ir_t;

  logic [2:0]    state, state_nxt;
  ir_t           ir;
  logic [CW-1:0] exec_cnt;
  logic          multi_cycle, is_halt, no_write;
  logic          exec_finish, exec_timeout;
  logic          unused_instr;

  assign unused_instr = ^instr;

  assign multi_cycle = ir.op[5];
  assign is_halt     = (ir.op == 6'b111111);
  assign no_write    = (ir.op[5:3] == 3'b111);

  // alu_done only matters while a multi-cycle op is executing.
  assign exec_finish  = !multi_cycle || alu_done;
  assign exec_timeout = multi_cycle && !alu_done && (exec_cnt == EXEC_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (instr_valid) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = is_halt ? S_HALTED : S_EXECUTE;
      S_EXECUTE: begin
        if (exec_finish)       state_nxt = S_WRITEBACK;
        else if (exec_timeout) state_nxt = S_IDLE;
      end
      S_WRITEBACK: state_nxt = S_IDLE;
      S_HALTED:    state_nxt = S_HALTED;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      exec_cnt    <= '0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && instr_valid)
        ir <= ir_t'(instr[15:4]);
      if (state == S_EXECUTE)
        exec_cnt <= exec_cnt + 1'b1;
      else
        exec_cnt <= '0;
      if (state == S_EXECUTE && !exec_finish && exec_timeout)
        error <= 1'b1;
      if (state == S_WRITEBACK)
        instr_count <= instr_count + 16'd1;
    end
  end

  // Status and strobes are pure functions of state/IR so reset clears them in one edge.
  assign instr_ready       = (state == S_IDLE);
  assign busy              = (state == S_DECODE) || (state == S_EXECUTE) ||
                             (state == S_WRITEBACK);
  assign halted            = (state == S_HALTED);
  assign alu_start         = (state == S_EXECUTE) && (exec_cnt == '0);
  assign write_enable      = (state == S_WRITEBACK) && !no_write;
  assign opcode            = ir.op;
  assign read_sources_1    = ir.src1;
  assign read_sources_2    = ir.src2;
  assign write_destination = ir.dst;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle comparison against a cycle-age
// transaction model, plus hand-computed literal checks.
module tb_control_unit;
  localparam int W  = 16;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst, instr_valid, alu_done;
  logic [W-1:0] instr;
  logic         instr_ready, alu_start, write_enable, busy, halted, error;
  logic [5:0]   opcode;
  logic [1:0]   read_sources_1, read_sources_2, write_destination;
  logic [15:0]  instr_count;

  control_unit #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_done(alu_done), .alu_start(alu_start),
    .opcode(opcode), .read_sources_1(read_sources_1),
    .read_sources_2(read_sources_2), .write_destination(write_destination),
    .write_enable(write_enable), .busy(busy), .halted(halted), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since accept (1 = decode, >=2 = execute cycle age-1).
  logic [15:0] m_ir  = '0;
  logic [15:0] m_cnt = '0;
  int          m_age = 0;
  bit          m_wb = 0, m_halt = 0, m_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ir = '0; m_cnt = '0; m_age = 0; m_wb = 0; m_halt = 0; m_err = 0;
    end else if (m_halt) begin
    end else if (m_wb) begin
      m_wb = 0;
      m_cnt = m_cnt + 16'd1;
    end else if (m_age == 0) begin
      if (instr_valid) begin
        m_ir  = instr[15:0];
        m_age = 1;
      end
    end else if (m_age == 1) begin
      if (m_ir[15:10] == 6'h3F) begin m_halt = 1; m_age = 0; end
      else m_age = 2;
    end else begin
      if (!m_ir[15] || alu_done) begin m_wb = 1; m_age = 0; end
      else if (m_age - 1 == TO) begin m_err = 1; m_age = 0; end
      else m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",  instr_ready, 32'(!m_halt && m_age == 0 && !m_wb));
      check("busy",   busy,        32'(m_age != 0 || m_wb));
      check("halted", halted,      32'(m_halt));
      check("error",  error,       32'(m_err));
      check("start",  alu_start,   32'(m_age == 2));
      check("we",     write_enable, 32'(m_wb && m_ir[15:13] != 3'b111));
      check("opcode", opcode,      32'(m_ir[15:10]));
      check("dst",    write_destination, 32'(m_ir[9:8]));
      check("src1",   read_sources_1,    32'(m_ir[7:6]));
      check("src2",   read_sources_2,    32'(m_ir[5:4]));
      check("count",  instr_count, 32'(m_cnt));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; instr_valid = 0; instr = '0; alu_done = 0;
    @(posedge clk); tick(); chk_en = 1;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", instr_count, 0);
    check("rst_opcode", opcode, 0);
    rst = 0;

    // single-cycle 12A0: write three cycles after accept
    instr_valid = 1; instr = 16'h12A0; tick(); instr_valid = 0;
    check("t1_op", opcode, 6'b000100);
    check("t1_src1", read_sources_1, 2);
    check("t1_src2", read_sources_2, 2);
    check("t1_dst", write_destination, 2);
    tick(); check("t1_start", alu_start, 1);
    tick(); check("t1_we", write_enable, 1);
    tick(); check("t1_count", instr_count, 1); check("t1_we_off", write_enable, 0);

    // multi-cycle 91E0, done in fourth execute cycle
    instr_valid = 1; instr = 16'h91E0; tick(); instr_valid = 0;
    tick(); check("t2_start", alu_start, 1);
    tick(); check("t2_start_once", alu_start, 0);
    tick();
    tick(); alu_done = 1;
    tick(); alu_done = 0;
    check("t2_we", write_enable, 1);
    check("t2_dst", write_destination, 1);
    check("t2_src1", read_sources_1, 3);
    check("t2_src2", read_sources_2, 2);
    tick(); check("t2_count", instr_count, 2);

    // E000: alu_done in idle/decode ignored, no write, still retires
    alu_done = 1; tick();
    instr_valid = 1; instr = 16'hE000; tick(); instr_valid = 0;
    tick(); alu_done = 0; check("t3_in_exec", busy, 1);
    tick(); check("t3_still_exec", write_enable, 0); alu_done = 1;
    tick(); alu_done = 0; check("t3_wb_busy", busy, 1); check("t3_no_we", write_enable, 0);
    tick(); check("t3_count", instr_count, 3);

    // timeout: 15 execute cycles without alu_done
    instr_valid = 1; instr = 16'h91E0; tick(); instr_valid = 0;
    repeat (TO) tick();
    check("t4_err_pre", error, 0); check("t4_busy_pre", busy, 1);
    tick();
    check("t4_err", error, 1); check("t4_ready", instr_ready, 1);
    check("t4_count", instr_count, 3);

    // back-to-back: valid held high, second accept right after writeback
    instr_valid = 1; instr = 16'h0400; tick(); instr = 16'h2F50;
    tick(); tick(); check("t5_we", write_enable, 1);
    tick(); check("t5_count", instr_count, 4); check("t5_ready", instr_ready, 1);
    tick(); instr_valid = 0;
    check("t5_op2", opcode, 6'b001011);
    tick(); tick(); check("t5_we2", write_enable, 1); check("t5_dst2", write_destination, 3);
    tick(); check("t5_count2", instr_count, 5); check("t5_err_sticky", error, 1);

    // reset mid-execute
    instr_valid = 1; instr = 16'h91E0; tick(); instr_valid = 0;
    tick(); tick(); rst = 1;
    tick();
    check("t6_ready", instr_ready, 1); check("t6_busy", busy, 0);
    check("t6_err", error, 0); check("t6_count", instr_count, 0);
    check("t6_op", opcode, 0); check("t6_we", write_enable, 0);
    check("t6_start", alu_start, 0);
    rst = 0; tick();

    // halt, ignore inputs, leave via reset
    instr_valid = 1; instr = 16'hFC00; tick(); instr_valid = 0;
    tick(); check("t7_halted", halted, 1); check("t7_ready", instr_ready, 0);
    instr_valid = 1; instr = 16'h12A0; alu_done = 1;
    repeat (3) tick();
    check("t7_hold", halted, 1); check("t7_op", opcode, 6'h3F); check("t7_busy", busy, 0);
    instr_valid = 0; alu_done = 0; rst = 1;
    tick(); check("t7_rst_ready", instr_ready, 1); check("t7_rst_halted", halted, 0);
    rst = 0; tick(); tick();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter W, default 16: instruction width (fields below fixed in bits [15:0]).
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum EXECUTE cycles waiting for alu_done.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  upstream instruction available.
REQ-006 SHALL have port instr  input  W  instruction: [15:10] opcode, [9:8] dst, [7:6] src1, [5:4] src2, [3:0] unused.
REQ-007 SHALL have port instr_ready  output  1  block accepts instruction this cycle.
REQ-008 SHALL have port alu_done  input  1  multi-cycle ALU result ready.
REQ-009 SHALL have port alu_start  output  1  one-cycle pulse starting ALU operation.
REQ-010 SHALL have port opcode  output  6  register-file opcode.
REQ-011 SHALL have ports read_sources_1 and read_sources_2  output  2 each  register-file read addresses.
REQ-012 SHALL have port write_destination  output  2  register-file write address.
REQ-013 SHALL have port write_enable  output  1  register-file write strobe.
REQ-014 SHALL have ports busy, halted, error  output  1 each  status flags.
REQ-015 SHALL have port instr_count  output  16  retired-instruction counter.

Function
REQ-016 SHALL implement states IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
REQ-017 IDLE: instr_ready=1; instr_valid=1 latches instr into IR, next state DECODE; otherwise stay.
REQ-018 instr_ready SHALL be 0 in every state except IDLE; busy = (state is DECODE, EXECUTE or WRITEBACK).
REQ-019 opcode, read_sources_1/2, write_destination SHALL be driven from IR, stable from DECODE until the next accept.
REQ-020 DECODE: opcode 6'b111111 -> HALTED; otherwise -> EXECUTE after exactly one cycle.
REQ-021 alu_start SHALL pulse high exactly in the first EXECUTE cycle of each instruction.
REQ-022 Single-cycle class (opcode[5]=0): EXECUTE lasts one cycle, alu_done ignored, -> WRITEBACK.
REQ-023 Multi-cycle class (opcode[5]=1): stay in EXECUTE until alu_done=1 (done in first EXECUTE cycle accepted), then -> WRITEBACK.
REQ-024 Timeout: multi-cycle EXECUTE reaching TIMEOUT cycles without alu_done -> error=1 (sticky until reset), -> IDLE, no write, instr_count unchanged.
REQ-025 alu_done outside EXECUTE SHALL be ignored.
REQ-026 WRITEBACK: one cycle; write_enable=1 only if opcode[5:3]!=3'b111; then -> IDLE.
REQ-027 write_enable SHALL be 0 in every state other than WRITEBACK.
REQ-028 instr_count SHALL increment by 1 on each WRITEBACK exit (including no-write instructions), wrapping 16'hFFFF -> 16'h0000.
REQ-029 Minimum latency accept -> write_enable: 3 cycles (DECODE, EXECUTE, WRITEBACK); back-to-back accept possible the cycle after WRITEBACK.
REQ-030 HALTED: halted=1, instr_ready=0, ignores all inputs until rst.

Reset
REQ-031 rst=1 at a rising edge SHALL force state IDLE, IR=0, all outputs 0 except instr_ready=1, regardless of current state.
REQ-032 rst asserted mid-instruction SHALL suppress any pending write_enable and leave instr_count at 0.

Verification
REQ-033 Accept 16'h12A0 -> opcode=6'b000100, src1=2, src2=2, dst=2; write_enable=1 exactly 3 cycles after accept; instr_count=1.
REQ-034 Accept 16'h91E0, alu_done after 4 EXECUTE cycles -> alu_start one pulse, write_enable=1 with dst=1 the cycle after alu_done, src1=3, src2=2.
REQ-035 Accept 16'hE000 -> passes WRITEBACK with write_enable=0, instr_count increments.
REQ-036 Accept 16'h91E0, alu_done never -> after 15 EXECUTE cycles error=1, state IDLE, no write, instr_count unchanged.
REQ-037 Accept 16'hFC00 -> halted=1, instr_ready=0; further instr_valid ignored; rst -> instr_ready=1, halted=0.
REQ-038 rst during EXECUTE of 16'h91E0 -> next cycle all outputs at reset values, no write_enable pulse observed.
